// File: rtl/muldiv_pkg.sv
// Shared encodings and decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Divide/remainder ops all have funct3[2] set.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // MUL keeps operands unsigned: the low half of the product is sign-agnostic.
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(parameter int unsigned XLEN = 32);

    logic            valid_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  stall_o, done_o, result_o
    );

    modport slave (
        input  valid_i, funct3_i, rs1_i, rs2_i, flush_i,
        output stall_o, done_o, result_o
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// {hi,lo} is the running product (multiplier in lo) or {remainder, dividend/quotient}.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] next_hi,
    output logic [XLEN-1:0] next_lo
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    logic          fits;

    // Multiply step by default; divide overrides when selected.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        trial   = {hi, lo[XLEN-1]} - {1'b0, b};
        fits    = ~trial[XLEN];
        next_hi = sum[XLEN:1];
        next_lo = {sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            next_hi = fits ? trial[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
            next_lo = {lo[XLEN-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit with pipeline stall and flush.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    muldiv_if.slave  bus
);

    localparam int unsigned ITER = XLEN / UNROLL;
    localparam int unsigned CW   = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic [XLEN-1:0] hi, lo, opb;
    logic            neg_q, neg_r;

    logic            accept, last, special, sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b, special_res, fix_res;
    logic [2*XLEN-1:0] prod;
    logic [UNROLL:0][XLEN-1:0] chain_hi, chain_lo;

    // Operand magnitudes and the divide cases that bypass the iterative engine.
    always_comb begin
        accept      = (state == S_IDLE) && bus.valid_i && !bus.flush_i;
        last        = (cnt == CW'(ITER - 1));
        sign_a      = is_signed_a(bus.funct3_i) & bus.rs1_i[XLEN-1];
        sign_b      = is_signed_b(bus.funct3_i) & bus.rs2_i[XLEN-1];
        abs_a       = sign_a ? -bus.rs1_i : bus.rs1_i;
        abs_b       = sign_b ? -bus.rs2_i : bus.rs2_i;
        special     = 1'b0;
        special_res = '0;
        if (is_div(bus.funct3_i)) begin
            if (bus.rs2_i == '0) begin
                special     = 1'b1;
                special_res = bus.funct3_i[1] ? bus.rs1_i : '1;
            end else if (is_signed_a(bus.funct3_i) && bus.rs1_i == MIN_NEG && bus.rs2_i == '1) begin
                special     = 1'b1;
                special_res = bus.funct3_i[1] ? '0 : bus.rs1_i;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic; flush wins from any state.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = special ? S_DONE : S_RUN;
            S_RUN:   if (last) state_n = S_FIX;
            S_FIX:   state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (bus.flush_i) state_n = S_IDLE;
    end

    // Stall is combinational so the accept cycle already holds the pipeline.
    always_comb begin
        bus.stall_o = 1'b0;
        if (!rst_i && (accept || state == S_RUN || state == S_FIX)) bus.stall_o = 1'b1;
    end

    // Sign fix-up and half selection applied in FIX.
    always_comb begin
        prod    = neg_q ? -{hi, lo} : {hi, lo};
        fix_res = prod[XLEN-1:0];
        case (op)
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = neg_q ? -lo : lo;
            F3_REM, F3_REMU:              fix_res = neg_r ? -hi : hi;
            default:                      fix_res = prod[XLEN-1:0];
        endcase
    end

    assign chain_hi[0] = hi;
    assign chain_lo[0] = lo;

    // UNROLL radix-2 steps chained combinationally per cycle.
    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div  (op[2]),
            .hi      (chain_hi[g]),
            .lo      (chain_lo[g]),
            .b       (opb),
            .next_hi (chain_hi[g+1]),
            .next_lo (chain_lo[g+1])
        );
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt          <= '0;
            op           <= F3_MUL;
            hi           <= '0;
            lo           <= '0;
            opb          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            bus.done_o   <= 1'b0;
            bus.result_o <= '0;
        end else begin
            bus.done_o <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    op    <= bus.funct3_i;
                    cnt   <= '0;
                    hi    <= '0;
                    lo    <= is_div(bus.funct3_i) ? abs_a : abs_b;
                    opb   <= is_div(bus.funct3_i) ? abs_b : abs_a;
                    neg_q <= sign_a ^ sign_b;
                    neg_r <= sign_a;
                    if (special) begin
                        bus.result_o <= special_res;
                        bus.done_o   <= 1'b1;
                    end
                end
                S_RUN: begin
                    hi  <= chain_hi[UNROLL];
                    lo  <= chain_lo[UNROLL];
                    cnt <= cnt + CW'(1);
                end
                S_FIX: if (!bus.flush_i) begin
                    bus.result_o <= fix_res;
                    bus.done_o   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
